// File: rtl/seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
// Optional feature: define SINGLE_STEP_EN to add step_i single-instruction stepping from IDLE.
`timescale 1ns/1ps

module seq_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
`ifdef SINGLE_STEP_EN
    input  logic              step_i,
`endif
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              z_i,
    input  logic              c_i,
    output logic              wr_o,
    output logic              wf_o,
    output logic              alu_o,
    output logic              ldi_o,
    output logic [ADDR_W-1:0] imm_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] ir_o,
    output logic              busy_o
);

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_LDA = 3'b010;
    localparam logic [OP_W-1:0] OP_STA = 3'b011;
    localparam logic [OP_W-1:0] OP_JMP = 3'b100;
    localparam logic [OP_W-1:0] OP_JZ  = 3'b101;
    localparam logic [OP_W-1:0] OP_JC  = 3'b110;
    localparam logic [OP_W-1:0] OP_LDI = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC_MEM = 3'd3,
        S_EXEC     = 3'd4
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
`ifdef SINGLE_STEP_EN
    logic              step_q;
`endif

    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] imm;
    logic              is_fetch;
    logic              is_mem;
    logic              is_exec;
    logic              mem_done;
    logic              jump_taken;
    state_e            boundary_state;

    assign op       = ir_q[DATA_W-1 -: OP_W];
    assign imm      = ir_q[ADDR_W-1:0];
    assign is_fetch = (state_q == S_FETCH);
    assign is_mem   = (state_q == S_EXEC_MEM);
    assign is_exec  = (state_q == S_EXEC);
    assign mem_done = is_mem & mem_ack_i;

    assign jump_taken = (op == OP_JMP)
                      | ((op == OP_JZ) & z_i)
                      | ((op == OP_JC) & c_i);

    // run_i is only consulted here, at the end of an instruction
    assign boundary_state = run_i ? S_FETCH : S_IDLE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
`ifdef SINGLE_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        state_q <= S_FETCH;
                    end
`ifdef SINGLE_STEP_EN
                    else if (step_i) begin
                        state_q <= S_FETCH;
                        step_q  <= 1'b1;
                    end
`endif
                end
                S_FETCH: begin
                    if (mem_ack_i) begin
                        ir_q    <= mem_rdata_i;
                        pc_q    <= pc_q + ADDR_W'(1);
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= op[OP_W-1] ? S_EXEC : S_EXEC_MEM;
                end
                S_EXEC_MEM: begin
                    if (mem_ack_i) begin
                        state_q <= boundary_state;
`ifdef SINGLE_STEP_EN
                        step_q  <= 1'b0;
`endif
                    end
                end
                S_EXEC: begin
                    if (jump_taken) begin
                        pc_q <= imm;
                    end
                    state_q <= boundary_state;
`ifdef SINGLE_STEP_EN
                    step_q  <= 1'b0;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port is decoded from the registered state; stable until ack
    assign mem_req_o  = is_fetch | is_mem;
    assign mem_we_o   = is_mem & (op == OP_STA);
    assign mem_addr_o = is_fetch ? pc_q : (is_mem ? imm : '0);

    // Datapath strobes fire only in the completing execute cycle
    assign wr_o  = (mem_done & (op != OP_STA)) | (is_exec & (op == OP_LDI));
    assign wf_o  = mem_done & ((op == OP_ADD) | (op == OP_SUB));
    assign alu_o = mem_done & (op == OP_SUB);
    assign ldi_o = is_exec & (op == OP_LDI);

    assign imm_o  = imm;
    assign pc_o   = pc_q;
    assign ir_o   = ir_q;
    assign busy_o = (state_q != S_IDLE);

    logic unused_op_lda;
    assign unused_op_lda = (op == OP_LDA);

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: instruction-level reference model with directed and randomized programs.
`timescale 1ns/1ps

module tb_seq_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              run_i;
`ifdef SINGLE_STEP_EN
    logic              step_i;
`endif
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              z_i;
    logic              c_i;
    logic              wr_o;
    logic              wf_o;
    logic              alu_o;
    logic              ldi_o;
    logic [ADDR_W-1:0] imm_o;
    logic [ADDR_W-1:0] pc_o;
    logic [DATA_W-1:0] ir_o;
    logic              busy_o;

    seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .run_i       (run_i),
`ifdef SINGLE_STEP_EN
        .step_i      (step_i),
`endif
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .z_i         (z_i),
        .c_i         (c_i),
        .wr_o        (wr_o),
        .wf_o        (wf_o),
        .alu_o       (alu_o),
        .ldi_o       (ldi_o),
        .imm_o       (imm_o),
        .pc_o        (pc_o),
        .ir_o        (ir_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference state: program memory, architectural pc and ir
    logic [DATA_W-1:0] mem [32];
    logic [ADDR_W-1:0] pc_m;
    logic [DATA_W-1:0] ir_m;
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exec_cyc = 0;
    int cyc0     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {wr_o, wf_o, alu_o, ldi_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
        chk({tag, "_strobe"}, 32'(strobes()), 32'd0);
        chk({tag, "_pc"}, 32'(pc_o), 32'(pc_m));
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1; run_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        z_i = 1'b0; c_i = 1'b0;
`ifdef SINGLE_STEP_EN
        step_i = 1'b0;
`endif
        repeat (n) tick();
        rst_i = 1'b0;
        pc_m = '0;
        ir_m = '0;
    endtask

    // From IDLE: raise run_i and move into FETCH; a stray ack here must be ignored
    task automatic start();
        run_i = 1'b1;
        mem_ack_i = 1'($urandom);
        #1;
        chk("start_busy", 32'(busy_o), 32'd0);
        chk("start_req", 32'(mem_req_o), 32'd0);
        tick();
        mem_ack_i = 1'b0;
    endtask

    // One whole instruction, starting in its first FETCH cycle
    task automatic run_instr(input int fw, input int mw, input bit zv, input bit cv, input bit drop);
        logic [2:0]        op;
        logic [ADDR_W-1:0] im;
        bit                taken;
        bit                run_end;
        for (int i = 0; i <= fw; i++) begin
            if (drop) run_i = 1'b0;
            mem_ack_i   = (i == fw);
            mem_rdata_i = (i == fw) ? mem[pc_m] : 8'($urandom);
            #1;
            chk("fetch_req", 32'(mem_req_o), 32'd1);
            chk("fetch_we", 32'(mem_we_o), 32'd0);
            chk("fetch_addr", 32'(mem_addr_o), 32'(pc_m));
            chk("fetch_pc", 32'(pc_o), 32'(pc_m));
            chk("fetch_busy", 32'(busy_o), 32'd1);
            chk("fetch_strobe", 32'(strobes()), 32'd0);
            tick();
        end
        ir_m = mem[pc_m];
        pc_m = pc_m + 5'd1;
        op   = ir_m[7:5];
        im   = ir_m[4:0];

        mem_ack_i = 1'($urandom);
        #1;
        chk("dec_req", 32'(mem_req_o), 32'd0);
        chk("dec_ir", 32'(ir_o), 32'(ir_m));
        chk("dec_imm", 32'(imm_o), 32'(im));
        chk("dec_pc", 32'(pc_o), 32'(pc_m));
        chk("dec_strobe", 32'(strobes()), 32'd0);
        tick();

        run_end = 1'b0;
        if (op[2] == 1'b0) begin
            for (int i = 0; i <= mw; i++) begin
                mem_ack_i   = (i == mw);
                mem_rdata_i = 8'($urandom);
                #1;
                chk("mem_req", 32'(mem_req_o), 32'd1);
                chk("mem_addr", 32'(mem_addr_o), 32'(im));
                chk("mem_we", 32'(mem_we_o), 32'(op == 3'd3));
                if (i == mw) begin
                    chk("mem_strobe", 32'(strobes()),
                        32'({op != 3'd3, op <= 3'd1, op == 3'd1, 1'b0}));
                    exec_cyc = cyc;
                    run_end  = run_i;
                end else begin
                    chk("mem_wait_strobe", 32'(strobes()), 32'd0);
                end
                tick();
            end
        end else begin
            z_i = zv; c_i = cv;
            mem_ack_i = 1'($urandom);
            #1;
            chk("ex_req", 32'(mem_req_o), 32'd0);
            chk("ex_strobe", 32'(strobes()), 32'({op == 3'd7, 1'b0, 1'b0, op == 3'd7}));
            exec_cyc = cyc;
            run_end  = run_i;
            taken = (op == 3'd4) || (op == 3'd5 && zv) || (op == 3'd6 && cv);
            tick();
            if (taken) pc_m = im;
        end
        mem_ack_i = 1'b0;
        if (!run_end) begin
            #1;
            check_idle("end_idle");
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Reset with run_i low
        do_reset(5);
        #1;
        check_idle("rst");
        chk("rst_ir", 32'(ir_o), 32'd0);
        chk("rst_imm", 32'(imm_o), 32'd0);
        repeat (3) tick();
        check_idle("rst_hold");

        // LDI 7 ; ADD 20 with zero-wait memory
        mem[0] = 8'hE7; mem[1] = 8'h14; mem[20] = 8'h03;
        cyc0 = cyc;
        start();
        run_instr(0, 0, 1'b0, 1'b0, 1'b0);
        chk("ldi_cycle", 32'(exec_cyc - cyc0), 32'd3);
        run_instr(0, 0, 1'b0, 1'b0, 1'b0);
        chk("add_cycle", 32'(exec_cyc - cyc0), 32'd6);
        chk("add_pc", 32'(pc_o), 32'd2);

        // SUB 20 ; JZ 9, taken and not taken
        for (int k = 0; k < 2; k++) begin
            do_reset(2);
            mem[0] = 8'h34; mem[1] = 8'hA9;
            start();
            run_instr(0, 0, 1'b0, 1'b0, 1'b0);
            run_i = 1'b0;
            run_instr(0, 0, (k == 0), 1'b0, 1'b0);
            chk("jz_pc", 32'(pc_o), (k == 0) ? 32'd9 : 32'd2);
        end

        // STA 15 with two wait states, then stop
        do_reset(2);
        mem[0] = 8'h6F;
        start();
        run_instr(0, 2, 1'b0, 1'b0, 1'b1);

        // JMP 31 ; JC 4 with carry clear wraps pc to 0, then run dropped mid-fetch
        do_reset(2);
        mem[0] = 8'h9F; mem[31] = 8'hC4;
        start();
        run_instr(0, 0, 1'b0, 1'b0, 1'b0);
        chk("jmp31_pc", 32'(pc_o), 32'd31);
        run_instr(1, 0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc", 32'(pc_o), 32'd0);
        run_instr(1, 0, 1'b0, 1'b0, 1'b1);
        chk("drop_pc", 32'(pc_o), 32'd31);

        // Reset landing in the middle of a fetch wait
        start();
        mem_ack_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; run_i = 1'b0; pc_m = '0;
        check_idle("midrst");

`ifdef SINGLE_STEP_EN
        // One step pulse, then step held high: one instruction per IDLE visit
        for (int i = 0; i < 32; i++) mem[i] = 8'hE0 | 8'(i);
        step_i = 1'b1;
        #1;
        chk("step_idle", 32'(busy_o), 32'd0);
        tick();
        step_i = 1'b0;
        run_instr(0, 0, 1'b0, 1'b0, 1'b0);
        chk("step_pc", 32'(pc_o), 32'd1);
        repeat (2) tick();
        check_idle("step_stay");
        step_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            run_instr(0, 0, 1'b0, 1'b0, 1'b0);
            chk("step_hold_pc", 32'(pc_o), 32'(k + 2));
        end
        step_i = 1'b0;
`endif

        // Randomized programs, wait states, flags and run gaps
        do_reset(2);
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        start();
        for (int k = 0; k < 60; k++) begin
            run_i = ($urandom_range(0, 5) != 0);
            run_instr($urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom), 1'($urandom), 1'b0);
            if (!run_i) begin
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    check_idle("rnd_idle");
                end
                start();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle instruction sequencer for the accumulator CPU. It fetches an 8-bit instruction from unified memory over a req/ack handshake, decodes the 3-bit opcode and runs the execute phase. During execute it drives the datapath strobes (accumulator write, flag write, ALU select, immediate load) and the memory write. It owns the program counter and instruction register and sits between the memory port and the accumulator/ALU datapath.

## Interface
- ADDR_W, 5, memory address width; also the operand/immediate field width
- DATA_W, 8, instruction/memory word width; opcode is bits [DATA_W-1:DATA_W-3]
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- run_i  in  1  level; high lets the sequencer start and keep executing instructions
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write (STA), 0 = read
- mem_addr_o  out  ADDR_W  request address
- mem_ack_i  in  1  request completed this cycle
- mem_rdata_i  in  DATA_W  read data, valid when mem_ack_i high on a read
- z_i  in  1  zero flag from status register
- c_i  in  1  carry flag from status register
- wr_o  out  1  accumulator write strobe
- wf_o  out  1  status-register write strobe
- alu_o  out  1  ALU op select: 0 = add, 1 = sub
- ldi_o  out  1  accumulator source = immediate
- imm_o  out  ADDR_W  IR[ADDR_W-1:0], zero-extended by the datapath
- pc_o  out  ADDR_W  program counter
- ir_o  out  DATA_W  instruction register
- busy_o  out  1  high in any state except IDLE
- step_i  in  1  only present with SINGLE_STEP_EN; see Configuration

## Operation
- Opcodes:
  - 000 ADD: read [imm], acc+=data, write flags
  - 001 SUB: read [imm], acc-=data, write flags
  - 010 LDA: read [imm], acc=data
  - 011 STA: write acc to [imm]
  - 100 JMP
  - 101 JZ: taken if z_i
  - 110 JC: taken if c_i
  - 111 LDI: acc=imm
- States: IDLE, FETCH, DECODE, EXEC_MEM, EXEC.
  - IDLE: go to FETCH when run_i=1.
  - FETCH: req=1, we=0, addr=pc. On ack: IR<=mem_rdata_i, pc<=pc+1 (wraps modulo 2^ADDR_W, 31->0), go to DECODE.
  - DECODE: opcodes 000–011 go to EXEC_MEM; others go to EXEC.
  - EXEC_MEM: req=1, addr=imm, we=1 only for STA. On ack, for ADD/SUB/LDA, drive combinationally in that ack cycle:
    - wr_o=1
    - wf_o=1 for ADD/SUB
    - alu_o=1 for SUB
  - EXEC: jumps load pc<=imm if taken; otherwise pc is unchanged. LDI drives wr_o=1 and ldi_o=1 combinationally in this cycle.
  - After EXEC_MEM ack or EXEC: go to FETCH if run_i=1, else IDLE. run_i is only checked at instruction boundaries; dropping it mid-instruction never aborts.
- mem_we_o=1 only in EXEC_MEM while executing STA. The datapath supplies the write data.
- Strobes wr_o/wf_o/ldi_o are never high outside the cycles above. alu_o=0 except during a SUB ack cycle.

## Timing
- Reset values: state=IDLE, pc=0, ir=0. All outputs are 0: mem_req_o, mem_we_o, mem_addr_o, wr_o, wf_o, alu_o, ldi_o, imm_o, busy_o.
- mem_req_o rises on the cycle after entering FETCH/EXEC_MEM is decided; it is registered state, with outputs decoded from state.
- Handshake:
  - req, we and addr stay stable until the cycle in which ack is sampled high.
  - Zero-wait memory may assert ack in the first req cycle.
  - req is 0 in the cycle after ack.
  - mem_ack_i is ignored when req=0.
- Cycles per instruction with zero-wait memory: 3 for every opcode (FETCH, DECODE, EXEC or EXEC_MEM). Each wait state adds 1 cycle.
- z_i/c_i are sampled in the EXEC cycle, so flags written by the preceding ADD/SUB are visible to an immediately following JZ/JC.
- A reset asserted mid-operation takes effect at the next edge: req drops, no strobe is issued, pc=0.

## Configuration
- SINGLE_STEP_EN defined:
  - Adds the step_i port.
  - In IDLE with run_i=0, step_i=1 starts exactly one instruction, then returns to IDLE regardless of step_i.
  - step_i is ignored outside IDLE.
  - run_i=1 behaves as normal.
- SINGLE_STEP_EN undefined: no step_i port; IDLE exits only on run_i.

## Test plan
- Reset with run_i=0 for 5 cycles -> all outputs 0, busy_o=0, no req.
- Program [0]=LDI 7, [1]=ADD 20 with mem[20]=3, zero-wait memory, run_i=1 -> wr_o+ldi_o pulse at cycle 3 with imm_o=7. Then wr_o+wf_o pulse, alu_o=0, addr=20 at cycle 6. pc_o=2.
- [0]=SUB 20, [1]=JZ 9 with z_i=1 in the JZ EXEC cycle -> alu_o=1 during SUB ack; pc_o=9 after JZ. Repeat with z_i=0 -> pc_o=2.
- STA 15 with 2 wait cycles on ack -> mem_we_o=1 and mem_addr_o=15 held for 3 cycles, req low the next cycle, no wr_o.
- pc=31 fetching JC 4 with c_i=0 -> pc_o wraps to 0. Then drop run_i mid-fetch -> current instruction completes, then IDLE and busy_o=0.
- SINGLE_STEP_EN: run_i=0, one step_i pulse -> exactly one instruction executes, pc_o advances by 1, then IDLE; holding step_i high executes one instruction per IDLE visit.
